instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the five-stage MIPS pipeline: owns the program counter, issues word requests to an instruction memory with variable latency (req/ack), and drives the instruction, valid flag and PC+4 that the IF/ID pipeline register captures every cycle. It is the producer side of the IF/ID interface. It handles hazard-unit stalls by freezing its outputs and buffering a returned word. It handles branch/jump redirects by discarding in-flight fetches and inserting NOP bubbles.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset (bits [1:0] must be 0).
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold the IF/ID-facing outputs and the PC.
- redirect  in  1  one-cycle pulse from branch/jump resolution (also used as flush).
- redirectTarget  in  32  new fetch address; bits [1:0] forced to 0 internally.
- imemReq  out  1  request outstanding to instruction memory.
- imemAddr  out  32  word address of the outstanding request; stable while imemReq=1.
- imemAck  in  1  memory returns data this cycle; ignored when imemReq=0.
- imemData  in  32  instruction word, valid when imemAck=1.
- instrOut  out  32  instruction to IF/ID (NOP = 32'h0000_0000 when invalid).
- validOut  out  1  instrOut is a real instruction.
- pcPlus4Out  out  32  address of instrOut + 4, mod 2^32; 0 when validOut=0.

## Operation
- States: FETCH (request pending at pc), HOLD (word buffered, waiting for stall release), KILL (request pending at a stale address; returned word is dropped).
- imemReq = 1 in FETCH and KILL, 0 in HOLD. imemAddr = pc in FETCH, killAddr in KILL.
- FETCH, imemAck=1, stall=0: instrOut<=imemData, validOut<=1, pcPlus4Out<=pc+4, pc<=pc+4, stay FETCH. The new request goes out the next cycle.
- FETCH, imemAck=1, stall=1: holdReg<=imemData, holdPc<=pc, pc<=pc+4, go HOLD; outputs unchanged.
- FETCH, imemAck=0: stall=0 means outputs <= NOP/valid 0/pcPlus4 0 (bubble); stall=1 means outputs hold.
- HOLD, stall=0: outputs <= holdReg/1/holdPc+4, go FETCH. With stall=1, stay HOLD.
- redirect=1 has priority over stall and ack. At that edge: pc<=target, and outputs <= NOP/0/0 even when stall=1.
  - If in FETCH with imemAck=0: killAddr<=pc, go KILL.
  - If in FETCH with imemAck=1: drop the word, stay FETCH.
  - If in HOLD: drop holdReg, go FETCH.
  - If in KILL: pc<=target, stay KILL; a same-cycle ack is still dropped and the state goes FETCH.
- KILL, imemAck=1: drop data, go FETCH. Non-stalled cycles in KILL emit bubbles.
- pc arithmetic is 32-bit unsigned and wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset (asynchronous): state=FETCH, pc=RESET_PC, instrOut=0, validOut=0, pcPlus4Out=0, holdReg=0, killAddr=0. imemReq=1 and imemAddr=RESET_PC immediately after release.
- Latency: with a 1-cycle memory (ack in the same cycle as req), one instruction per cycle; a word appears on the outputs the edge after its ack.
- Memory with N-cycle latency: N-1 bubbles per instruction.
- Redirect: the first target-path word appears at the earliest edge after the target's ack. In the KILL case that is at least one extra memory round-trip.
- Reset mid-request: the outstanding request is abandoned. The memory must tolerate imemReq dropping without ack.
- Outputs are fully registered; imemReq/imemAddr are decoded from registered state only.

## Structure
- Package fetch_pkg: NOP_INSTR = 32'h0, the state enum {FETCH, HOLD, KILL}, RESET_PC default constant.
- One sub-module: pc_register, a 32-bit register with async reset to RESET_PC and load enable, instantiated for pc. holdReg and killAddr are plain registers in the top.

## Test plan
- Reset release, 1-cycle memory returning 32'h2008_0005 at 0x0, 0x0140_4820 at 0x4 → outputs those words, validOut=1, pcPlus4Out=0x4 then 0x8, one per cycle.
- 3-cycle memory latency → imemAddr stable for 3 cycles, 2 bubbles (instrOut=0, validOut=0) between valid words.
- stall=1 on the ack cycle for word at 0x8, held 2 cycles → outputs frozen, imemReq=0 while in HOLD, word appears on the edge after stall drops, pcPlus4Out=0xC.
- redirect to 0x40 while a 3-cycle fetch at 0x10 is pending → imemAddr stays 0x10 until ack, that word is never output, next request is at 0x40, first valid output has pcPlus4Out=0x44.
- redirect and stall high together → outputs become NOP/0 at that edge regardless of stall.
- redirectTarget=0xFFFF_FFFE, then sequential fetch → first fetch at 0xFFFF_FFFC, pcPlus4Out=0x0, next fetch at 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the instruction fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/ack bus plus the IF/ID-facing outputs and hazard controls
interface instr_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instrOut;
  logic        validOut;
  logic [31:0] pcPlus4Out;
  modport master (
    input  stall, redirect, redirectTarget, imemAck, imemData,
    output imemReq, imemAddr, instrOut, validOut, pcPlus4Out
  );
  modport slave (
    output stall, redirect, redirectTarget, imemAck, imemData,
    input  imemReq, imemAddr, instrOut, validOut, pcPlus4Out
  );
endinterface

// File: rtl/instr_fetch_unit_pc_register.sv
// pc_register: 32-bit program counter with load enable and async reset to a fixed address
module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= RESET_VAL;
    else if (ld) pc_q <= pc_d;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words over a variable-latency req/ack bus, and feeds IF/ID
// with stall buffering and redirect squashing.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_ld;
  logic [31:0] hold_reg_q, hold_reg_d, hold_pc_q, hold_pc_d, kill_addr_q, kill_addr_d;
  logic [31:0] instr_q, instr_d, pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk  (clk),
    .reset(reset),
    .ld   (pc_ld),
    .pc_d (pc_d),
    .pc_q (pc_q)
  );
  assign bus.imemReq    = state_q != HOLD;
  assign bus.imemAddr   = state_q == KILL ? kill_addr_q : pc_q;
  assign bus.instrOut   = instr_q;
  assign bus.validOut   = valid_q;
  assign bus.pcPlus4Out = pc_plus4_q;
  always_comb begin
    state_d     = state_q;
    pc_ld       = 1'b0;
    pc_d        = pc_q + 32'd4;
    hold_reg_d  = hold_reg_q;
    hold_pc_d   = hold_pc_q;
    kill_addr_d = kill_addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_plus4_d  = pc_plus4_q;
    if (bus.redirect) begin
      // A FETCH request with no ack yet must still be drained, so it becomes a stale KILL request.
      pc_ld       = 1'b1;
      pc_d        = bus.redirectTarget & ~32'h3;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      pc_plus4_d  = 32'd0;
      state_d     = (state_q == HOLD || bus.imemAck) ? FETCH : KILL;
      kill_addr_d = (state_q == FETCH && !bus.imemAck) ? pc_q : kill_addr_q;
    end else begin
      case (state_q)
        FETCH: begin
          pc_ld = bus.imemAck;
          if (bus.imemAck && bus.stall) begin
            hold_reg_d = bus.imemData;
            hold_pc_d  = pc_q;
            state_d    = HOLD;
          end else if (!bus.stall) begin
            instr_d    = bus.imemAck ? bus.imemData : NOP_INSTR;
            valid_d    = bus.imemAck;
            pc_plus4_d = bus.imemAck ? pc_q + 32'd4 : 32'd0;
          end
        end
        HOLD: if (!bus.stall) begin
          instr_d    = hold_reg_q;
          valid_d    = 1'b1;
          pc_plus4_d = hold_pc_q + 32'd4;
          state_d    = FETCH;
        end
        default: begin
          state_d = bus.imemAck ? FETCH : KILL;
          if (!bus.stall) begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            pc_plus4_d = 32'd0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= FETCH;
      hold_reg_q  <= 32'd0;
      hold_pc_q   <= 32'd0;
      kill_addr_q <= 32'd0;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      pc_plus4_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      hold_reg_q  <= hold_reg_d;
      hold_pc_q   <= hold_pc_d;
      kill_addr_q <= kill_addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      pc_plus4_q  <= pc_plus4_d;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random stall/redirect/latency stimulus against an in-bench fetch model,
// plus directed scenarios pinned with literal expectations.
module tb_instr_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  instr_fetch_unit_if bus ();
  instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  int lat_sel = 1;
  int cnt = 0;
  bit          m_buffered, m_stale, m_valid;
  logic [31:0] m_pc, m_buf, m_buf_pc, m_stale_addr, m_instr, m_pc4;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h0140_4820;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_buffered = 0; m_stale = 0; m_valid = 0;
    m_pc = 32'h0; m_buf = 0; m_buf_pc = 0; m_stale_addr = 0; m_instr = 0; m_pc4 = 0;
  endtask
  task automatic emit(input bit v, input logic [31:0] ins, input logic [31:0] p4);
    m_valid = v; m_instr = ins; m_pc4 = p4;
  endtask
  task automatic model_step(input bit s, input bit r, input logic [31:0] t, input bit a, input logic [31:0] d);
    if (r) begin
      emit(0, 0, 0);
      if (m_buffered) m_buffered = 0;
      else if (m_stale) m_stale = !a;
      else if (!a) begin m_stale = 1; m_stale_addr = m_pc; end
      m_pc = {t[31:2], 2'b00};
    end else if (m_buffered) begin
      if (!s) begin emit(1, m_buf, m_buf_pc + 4); m_buffered = 0; end
    end else if (m_stale) begin
      if (a) m_stale = 0;
      if (!s) emit(0, 0, 0);
    end else if (a) begin
      if (s) begin m_buffered = 1; m_buf = d; m_buf_pc = m_pc; end
      else emit(1, d, m_pc + 4);
      m_pc = m_pc + 4;
    end else if (!s) emit(0, 0, 0);
  endtask
  task automatic compare_all();
    chk("imemReq", 32'(bus.imemReq), 32'(!m_buffered));
    if (!m_buffered) chk("imemAddr", bus.imemAddr, m_stale ? m_stale_addr : m_pc);
    chk("instrOut", bus.instrOut, m_instr);
    chk("validOut", 32'(bus.validOut), 32'(m_valid));
    chk("pcPlus4Out", bus.pcPlus4Out, m_pc4);
    if (bus.validOut) chk("stream_word", bus.instrOut, mem_word(bus.pcPlus4Out - 32'd4));
  endtask
  task automatic step(input bit s, input bit r, input logic [31:0] t);
    bit a;
    bit rq;
    logic [31:0] d;
    rq = bus.imemReq;
    if (rq) begin
      if (cnt == 0) cnt = lat_sel != 0 ? lat_sel : int'($urandom_range(1, 4));
      a = (cnt == 1);
      d = a ? mem_word(bus.imemAddr) : $urandom;
    end else begin
      a = 1'($urandom_range(0, 1));
      d = $urandom;
    end
    bus.stall = s; bus.redirect = r; bus.redirectTarget = t; bus.imemAck = a; bus.imemData = d;
    @(posedge clk);
    model_step(s, r, t, a, d);
    if (rq) cnt = a ? 0 : cnt - 1;
    @(negedge clk);
    compare_all();
  endtask
  initial begin
    reset = 1'b1;
    bus.stall = 0; bus.redirect = 0; bus.redirectTarget = 0; bus.imemAck = 0; bus.imemData = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imemReq), 32'h1);
    chk("rst_addr", bus.imemAddr, 32'h0);
    chk("rst_valid", 32'(bus.validOut), 32'h0);
    chk("rst_pc4", bus.pcPlus4Out, 32'h0);
    compare_all();
    lat_sel = 1;
    step(0, 0, 0);
    chk("w0_instr", bus.instrOut, 32'h2008_0005);
    chk("w0_pc4", bus.pcPlus4Out, 32'h4);
    step(0, 0, 0);
    chk("w1_instr", bus.instrOut, 32'h0140_4820);
    chk("w1_pc4", bus.pcPlus4Out, 32'h8);
    step(1, 0, 0);
    chk("hold_req", 32'(bus.imemReq), 32'h0);
    chk("hold_instr", bus.instrOut, 32'h0140_4820);
    step(1, 0, 0);
    chk("hold2_pc4", bus.pcPlus4Out, 32'h8);
    step(0, 0, 0);
    chk("unhold_instr", bus.instrOut, 32'h5A52_FFFF);
    chk("unhold_pc4", bus.pcPlus4Out, 32'hC);
    lat_sel = 3;
    step(0, 0, 0);
    chk("lat3_bubble", 32'(bus.validOut), 32'h0);
    step(0, 0, 0);
    chk("lat3_addr", bus.imemAddr, 32'hC);
    step(0, 0, 0);
    chk("lat3_pc4", bus.pcPlus4Out, 32'h10);
    step(0, 0, 0);
    step(0, 1, 32'h40);
    chk("kill_addr", bus.imemAddr, 32'h10);
    step(0, 0, 0);
    chk("kill_drop", 32'(bus.validOut), 32'h0);
    chk("tgt_addr", bus.imemAddr, 32'h40);
    repeat (3) step(0, 0, 0);
    chk("tgt_pc4", bus.pcPlus4Out, 32'h44);
    step(1, 1, 32'h80);
    chk("redir_stall_valid", 32'(bus.validOut), 32'h0);
    chk("redir_stall_instr", bus.instrOut, 32'h0);
    lat_sel = 1;
    repeat (3) step(0, 0, 0);
    chk("tgt80_pc4", bus.pcPlus4Out, 32'h84);
    step(0, 1, 32'hFFFF_FFFE);
    chk("wrap_addr", bus.imemAddr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc4", bus.pcPlus4Out, 32'h0);
    chk("wrap_valid", 32'(bus.validOut), 32'h1);
    chk("wrap_next", bus.imemAddr, 32'h0);
    lat_sel = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom % 10 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (i == 1500) begin
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.validOut), 32'h0);
        chk("async_rst_addr", bus.imemAddr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        compare_all();
      end
      step($urandom % 4 == 0, $urandom % 12 == 0, t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
